// File: rtl/param_counter_pkg.sv
// Shared constants and helpers for the counter family.
//   CNT_DOWN / CNT_UP   : direction encodings for the 'up' input
//   MODE_WRAP / MODE_SAT: boundary behaviour encodings for 'sat_mode'
//   bin2gray            : binary-to-Gray conversion (caller narrows the result)
package param_counter_pkg;

    localparam logic CNT_DOWN  = 1'b0;
    localparam logic CNT_UP    = 1'b1;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam int unsigned GRAY_MAX_W = 32;

    // Widest supported conversion; callers cast the result down to their width.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/param_updown_counter.sv
// Fully synchronous up/down modulus counter with load, wrap/saturate mode,
// terminal-count flag and a registered wrap pulse.
//
// Parameters:
//   WIDTH    count width in bits (>=1)
//   MODULUS  number of states, count range 0..MODULUS-1 (2..2**WIDTH)
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset (count=0, wrap=0)
//   en          count enable, one step per edge
//   up          direction: 1 up, 0 down
//   load        synchronous load strobe (priority over en)
//   load_val    value to load, clamped to MODULUS-1
//   sat_mode    0 wrap at boundary, 1 saturate at boundary
//   count       registered count value
//   tc          terminal count, combinational from count/up
//   wrap        registered one-cycle pulse after a wrapping edge
//   count_gray  (only with PARAM_UPDOWN_COUNTER_GRAY_EN) registered Gray code
//               of count, reset 0. Gray code stays single-bit-changing across
//               the wrap only when MODULUS == 2**WIDTH, so use it for clock
//               domain crossing only in that configuration.
module param_updown_counter
    import param_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 2**WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
`ifdef PARAM_UPDOWN_COUNTER_GRAY_EN
    output logic [WIDTH-1:0] count_gray,
`endif
    output logic             wrap
);

    // Boundary value held one bit wider so MODULUS == 2**WIDTH compares cleanly.
    localparam logic [WIDTH:0] MAX_CNT = (WIDTH+1)'(MODULUS - 1);

    if (WIDTH < 1 || MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_param
        $error("param_updown_counter: MODULUS must be in 2..2**WIDTH");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH:0]   w_cnt_ext;
    logic             w_at_max;
    logic             w_at_zero;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_wrap_nxt;

    assign w_cnt_ext = {1'b0, r_count};
    assign w_at_max  = (w_cnt_ext == MAX_CNT);
    assign w_at_zero = (r_count == '0);

    // Next-state: load > enabled step > hold.
    always_comb begin
        w_count_nxt = r_count;
        w_wrap_nxt  = 1'b0;
        if (load) begin
            w_count_nxt = ({1'b0, load_val} > MAX_CNT) ? WIDTH'(MAX_CNT) : load_val;
        end else if (en) begin
            if (up == CNT_UP) begin
                if (!w_at_max) begin
                    w_count_nxt = WIDTH'(w_cnt_ext + (WIDTH+1)'(1));
                end else if (sat_mode == MODE_WRAP) begin
                    w_count_nxt = '0;
                    w_wrap_nxt  = 1'b1;
                end
            end else begin
                if (!w_at_zero) begin
                    w_count_nxt = WIDTH'(w_cnt_ext - (WIDTH+1)'(1));
                end else if (sat_mode == MODE_WRAP) begin
                    w_count_nxt = WIDTH'(MAX_CNT);
                    w_wrap_nxt  = 1'b1;
                end
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    // Wrap pulse register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_nxt;
        end
    end

`ifdef PARAM_UPDOWN_COUNTER_GRAY_EN
    logic [WIDTH-1:0] r_count_gray;

    // Gray code of the next count, so it lines up with count on every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count_gray <= '0;
        end else begin
            r_count_gray <= WIDTH'(bin2gray(GRAY_MAX_W'(w_count_nxt)));
        end
    end

    assign count_gray = r_count_gray;
`endif

    assign count = r_count;
    assign wrap  = r_wrap;
    assign tc    = ((up == CNT_UP) && w_at_max) || ((up == CNT_DOWN) && w_at_zero);

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Fully synchronous, parametrised up/down counter with modulus; replaces the ripple-chained toggle counter.
- All state bits change on the same clk edge, so there is no ripple skew.
- Adds enable, direction, parallel load, wrap/saturate mode, a terminal-count flag and a registered wrap pulse.
- Used as a generic event/cycle counter and divider inside larger datapaths.

Parameters:
- WIDTH, 4, count register width in bits (>=1).
- MODULUS, 2**WIDTH, number of count states; count range is 0..MODULUS-1. Legal range 2..2**WIDTH; an out-of-range value is an elaboration error.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; clears all state immediately when 0.
- en  input  1  count enable; one step per clk edge while high.
- up  input  1  direction; 1 counts up, 0 counts down.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value captured on load.
- sat_mode  input  1  0 wraps at the boundary, 1 saturates at the boundary.
- count  output  WIDTH  registered count value.
- tc  output  1  terminal-count flag (combinational from count/up).
- wrap  output  1  registered one-cycle pulse after a wrap event.

Behaviour:
- Reset: rst=0 forces count=0 and wrap=0 asynchronously. Release is synchronous in effect: the first update happens on the first rising clk edge with rst=1.
- Priority per edge: load > en > hold.
- Load:
  - count <= load_val if load_val <= MODULUS-1, otherwise count <= MODULUS-1 (clamp).
  - wrap <= 0.
  - en is ignored that cycle.
- Up step (en=1, up=1):
  - count < MODULUS-1: count+1.
  - count == MODULUS-1 and sat_mode=0: count <= 0, wrap <= 1.
  - count == MODULUS-1 and sat_mode=1: count holds, wrap <= 0.
- Down step (en=1, up=0):
  - count > 0: count-1.
  - count == 0 and sat_mode=0: count <= MODULUS-1, wrap <= 1.
  - count == 0 and sat_mode=1: count holds at 0, wrap <= 0.
- Hold (en=0, load=0): count holds, wrap <= 0.
- wrap is high for exactly one cycle, the cycle after the wrapping edge. Back-to-back wraps (e.g. MODULUS=2 counting continuously) give consecutive high cycles.
- tc = (up && count==MODULUS-1) || (!up && count==0). It is independent of en and sat_mode, with zero latency from count/up.
- Direction changes take effect on the next enabled edge; there are no dead cycles.
- Arithmetic:
  - Carried out in WIDTH+1 bits, so the boundary compare never overflows.
  - With MODULUS == 2**WIDTH, natural overflow must match the explicit wrap rule.
- Mid-operation reset: count returns to 0 asynchronously; any pending wrap pulse is dropped.

Optional Feature:
- Macro PARAM_UPDOWN_COUNTER_GRAY_EN.
- Defined:
  - Adds output count_gray [WIDTH], a registered Gray encoding of the next count value. It is updated on the same edge as count, so count_gray == bin2gray(count) every cycle.
  - Reset value is 0.
  - Only meaningful for crossing clock domains when MODULUS == 2**WIDTH; this must be documented in the header.
- Not defined: the port and register are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package param_counter_pkg holds:
  - the direction constants CNT_DOWN=1'b0 and CNT_UP=1'b1;
  - the mode constants MODE_WRAP=1'b0 and MODE_SAT=1'b1;
  - a bin2gray function reused by other counters and FIFOs.
- No sub-module is needed for the core.
- The next-state logic is a single always block plus a separate registered wrap flop.
- The Gray register lives inside the same module under the ifdef.

Test Plan (WIDTH=4, MODULUS=10 unless stated):
- Reset: rst=0 while count=7, asynchronously between edges -> count=0 and wrap=0 immediately, before the next clk edge.
- Up wrap: load 8, then en=1 up=1 sat_mode=0 for 3 cycles -> count 9,0,1. tc=1 while count=9. wrap=1 only in the cycle count shows 0.
- Down saturate: load 1, then en=1 up=0 sat_mode=1 for 3 cycles -> count 0,0,0. tc=1 from first 0 onward. wrap stays 0.
- Load priority and clamp: load=1 load_val=13 with en=1 up=1 -> count=9 (clamped), no increment that cycle. Next edge with en=1 -> count=0, wrap=1.
- Direction flip at boundary: count=0, up=0, sat_mode=0, en=1 -> count=9 with wrap pulse. Then up=1 -> count=0 with wrap pulse. tc follows up combinationally (1 at 9 with up=1; 0 at 9 with up=0).
- Full modulus (WIDTH=3, MODULUS=8, GRAY_EN defined): free-run up 16 cycles -> count 0..7,0..7. wrap pulses after 7->0 twice. count_gray == count ^ (count>>1) every cycle.
